// File: rtl/data_req_bridge.sv
// Bridges the pipeline memory port onto an SRAM-like data bus.
// One request register, an in-order store/load tag FIFO and a registered response.
module data_req_bridge #(
  parameter int MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic        resp_valid,
  output logic        resp_wr,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic [31:0] data_rdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok
);

  localparam logic [2:0] MAXC = 3'(MAX_OUT);
  localparam logic [1:0] MAXP = 2'(MAX_OUT - 1);

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic       pend;
  req_t       req_q;
  logic [2:0] cnt;
  logic [1:0] wptr;
  logic [1:0] rptr;
  logic [3:0] tag_q;
  logic       err_q;

  logic mis;
  logic accept;
  logic acc_ok;
  logic acc_err;
  logic push;
  logic pop;

  function automatic logic [1:0] nxt_ptr(input logic [1:0] p);
    return (p == MAXP) ? 2'd0 : p + 2'd1;
  endfunction

  // Alignment check on the presented access
  always_comb begin
    mis = 1'b0;
    unique case (mem_size)
      2'd0:    mis = 1'b0;
      2'd1:    mis = mem_addr[0];
      2'd2:    mis = |mem_addr[1:0];
      default: mis = 1'b1;
    endcase
  end

  // Errors wait for the bus to drain so responses stay in order
  always_comb begin
    mem_ready = resetn & ~pend & (cnt < MAXC) & ~err_q;
    if (mis && cnt != 3'd0)
      mem_ready = 1'b0;
  end

  assign accept  = mem_valid & mem_ready;
  assign acc_ok  = accept & ~mis;
  assign acc_err = accept & mis;
  assign push    = pend & data_addr_ok;
  assign pop     = data_data_ok & (cnt != 3'd0);

  assign data_req   = pend;
  assign data_wr    = req_q.wr;
  assign data_size  = req_q.size;
  assign data_addr  = req_q.addr;
  assign data_wdata = req_q.wdata;

  // Request register: loaded on accept, released by addr_ok
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend  <= 1'b0;
      req_q <= '0;
    end else if (acc_ok) begin
      pend        <= 1'b1;
      req_q.wr    <= mem_wr;
      req_q.size  <= mem_size;
      req_q.addr  <= mem_addr;
      req_q.wdata <= mem_wdata;
    end else if (push) begin
      pend <= 1'b0;
    end
  end

  // Outstanding count and tag FIFO pointers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt  <= 3'd0;
      wptr <= 2'd0;
      rptr <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 3'd1;
        2'b01:   cnt <= cnt - 3'd1;
        default: cnt <= cnt;
      endcase
      if (push)
        wptr <= nxt_ptr(wptr);
      if (pop)
        rptr <= nxt_ptr(rptr);
    end
  end

  // Tag storage: remembers store/load per issued request
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      tag_q <= '0;
    else if (push)
      tag_q[wptr] <= req_q.wr;
  end

  // Error flag blocks new accepts for the error response cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      err_q <= 1'b0;
    else
      err_q <= acc_err;
  end

  // Registered one-cycle response pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_valid <= 1'b0;
      resp_wr    <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else if (acc_err) begin
      resp_valid <= 1'b1;
      resp_wr    <= mem_wr;
      resp_err   <= 1'b1;
      resp_rdata <= '0;
    end else if (pop) begin
      resp_valid <= 1'b1;
      resp_wr    <= tag_q[rptr];
      resp_err   <= 1'b0;
      resp_rdata <= tag_q[rptr] ? 32'd0 : data_rdata;
    end else begin
      resp_valid <= 1'b0;
      resp_wr    <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end
  end

endmodule
